// File: rtl/tb_fll_regbus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fll_regbus
//  Brief    : Behavioural FLL model on a register-bus port. It holds the
//             configuration, status and relock-counter registers and runs a
//             lock state machine with a realistic settle time, so boot and
//             driver code can poll for lock.
//  Options  : FLL_LOCK_JITTER_EN - when defined, an 8-bit LFSR adds 0..15
//             cycles of variation to every settle period.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fll_regbus #(
  parameter int unsigned AddrWidth         = 48,
  parameter logic [15:0] DefaultMult       = 16'd1,
  parameter logic [15:0] DefaultLockCycles = 16'd16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 reg_ready_o,
  output logic                 lock_o,
  output logic [15:0]          mult_o,
  output logic [3:0]           div_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [1:0] c_IDX_STATUS  = 2'd0;
  localparam logic [1:0] c_IDX_CFG1    = 2'd1;
  localparam logic [1:0] c_IDX_CFG2    = 2'd2;
  localparam logic [1:0] c_IDX_RELOCKS = 2'd3;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] mult_q, mult_d;
  logic [3:0]  div_q, div_d;
  logic        lock_q, lock_d;
  logic [31:0] relocks_q, relocks_d;
  logic [15:0] cfg_mult_q, cfg_mult_d;
  logic [3:0]  cfg_div_q, cfg_div_d;
  logic        cfg_en_q, cfg_en_d;
  logic [15:0] lock_cycles_q, lock_cycles_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_capture;
  logic [11:0] w_off;
  logic [1:0]  w_idx;
  logic        w_acc_err;
  logic        w_wr_cfg1;
  logic        w_wr_cfg2;
  logic [31:0] w_rd_word;
  logic [15:0] w_new_mult;
  logic [3:0]  w_new_div;
  logic        w_new_en;
  logic [15:0] w_new_lock_cycles;
  logic [15:0] w_settle_load;

  // Upper address bits are deliberately ignored; only the 4-word window decodes.
  generate
    if (AddrWidth > 12) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^reg_addr_i[AddrWidth-1:12];
    end
  endgenerate

  // Reserved CFG1 bits are write-ignored.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i[30:20];

`ifdef FLL_LOCK_JITTER_EN
  logic [7:0]  lfsr_q, lfsr_d;
  logic [16:0] w_jit_sum;

  // Settle length = LOCK_CYCLES plus LFSR noise, saturated to 16 bits.
  always_comb begin
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    w_jit_sum     = {1'b0, lock_cycles_q} + {13'd0, lfsr_q[3:0]};
    w_settle_load = w_jit_sum[16] ? 16'hFFFF : w_jit_sum[15:0];
  end

  // Free-running jitter source.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  // Settle length is exactly LOCK_CYCLES.
  always_comb begin
    w_settle_load = lock_cycles_q;
  end
`endif

  // Request decode, per-byte write merge and read mux.
  always_comb begin
    w_capture = reg_valid_i && !ready_q;
    w_off     = reg_addr_i[11:0];
    w_idx     = w_off[3:2];
    w_acc_err = (w_off[1:0] != 2'd0) || (w_off[11:4] != 8'd0) ||
                (reg_write_i && ((w_idx == c_IDX_STATUS) || (w_idx == c_IDX_RELOCKS)));
    w_wr_cfg1 = w_capture && reg_write_i && !w_acc_err && (w_idx == c_IDX_CFG1);
    w_wr_cfg2 = w_capture && reg_write_i && !w_acc_err && (w_idx == c_IDX_CFG2);

    w_new_mult[7:0]         = reg_wstrb_i[0] ? reg_wdata_i[7:0]   : cfg_mult_q[7:0];
    w_new_mult[15:8]        = reg_wstrb_i[1] ? reg_wdata_i[15:8]  : cfg_mult_q[15:8];
    w_new_div               = reg_wstrb_i[2] ? reg_wdata_i[19:16] : cfg_div_q;
    w_new_en                = reg_wstrb_i[3] ? reg_wdata_i[31]    : cfg_en_q;
    w_new_lock_cycles[7:0]  = reg_wstrb_i[0] ? reg_wdata_i[7:0]   : lock_cycles_q[7:0];
    w_new_lock_cycles[15:8] = reg_wstrb_i[1] ? reg_wdata_i[15:8]  : lock_cycles_q[15:8];

    w_rd_word = 32'd0;
    case (w_idx)
      c_IDX_STATUS:  w_rd_word = {mult_q, 15'd0, lock_q};
      c_IDX_CFG1:    w_rd_word = {cfg_en_q, 11'd0, cfg_div_q, cfg_mult_q};
      c_IDX_CFG2:    w_rd_word = {16'd0, lock_cycles_q};
      c_IDX_RELOCKS: w_rd_word = relocks_q;
      default:       w_rd_word = 32'd0;
    endcase

    cfg_mult_d    = w_wr_cfg1 ? w_new_mult        : cfg_mult_q;
    cfg_div_d     = w_wr_cfg1 ? w_new_div         : cfg_div_q;
    cfg_en_d      = w_wr_cfg1 ? w_new_en          : cfg_en_q;
    lock_cycles_d = w_wr_cfg2 ? w_new_lock_cycles : lock_cycles_q;

    ready_d = w_capture;
    error_d = w_capture && w_acc_err;
    rdata_d = (w_capture && !reg_write_i && !w_acc_err) ? w_rd_word : 32'd0;
  end

  // Lock state machine; a CFG1 write committing this cycle overrides normal progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mult_d    = mult_q;
    div_d     = div_q;
    relocks_d = relocks_q;

    case (state_q)
      ST_SETTLE: begin
        if ((cnt_q == 16'd0) && (mult_q == cfg_mult_q)) begin
          state_d = ST_LOCKED;
          div_d   = cfg_div_q;
          if (relocks_q != 32'hFFFF_FFFF) relocks_d = relocks_q + 32'd1;
        end else begin
          if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
          if (mult_q < cfg_mult_q)      mult_d = mult_q + 16'd1;
          else if (mult_q > cfg_mult_q) mult_d = mult_q - 16'd1;
        end
      end
      default: ;
    endcase

    if (w_wr_cfg1) begin
      if (!w_new_en) begin
        // Disable: drop straight to IDLE, outputs freeze where they are.
        state_d   = ST_IDLE;
        cnt_d     = cnt_q;
        mult_d    = mult_q;
        div_d     = div_q;
        relocks_d = relocks_q;
      end else if (!cfg_en_q ||
                   ((state_q != ST_IDLE) &&
                    ((w_new_mult != cfg_mult_q) || (w_new_div != cfg_div_q)))) begin
        // Enable or retune: (re)start settling from the current multiplier.
        state_d   = ST_SETTLE;
        cnt_d     = w_settle_load;
        mult_d    = mult_q;
        div_d     = div_q;
        relocks_d = relocks_q;
      end
    end

    lock_d = (state_d == ST_LOCKED);
  end

  // All state, configuration and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      mult_q        <= 16'd0;
      div_q         <= 4'd0;
      lock_q        <= 1'b0;
      relocks_q     <= 32'd0;
      cfg_mult_q    <= DefaultMult;
      cfg_div_q     <= 4'd0;
      cfg_en_q      <= 1'b0;
      lock_cycles_q <= DefaultLockCycles;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mult_q        <= mult_d;
      div_q         <= div_d;
      lock_q        <= lock_d;
      relocks_q     <= relocks_d;
      cfg_mult_q    <= cfg_mult_d;
      cfg_div_q     <= cfg_div_d;
      cfg_en_q      <= cfg_en_d;
      lock_cycles_q <= lock_cycles_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
      rdata_q       <= rdata_d;
    end
  end

  assign reg_ready_o = ready_q;
  assign reg_error_o = error_q;
  assign reg_rdata_o = rdata_q;
  assign lock_o      = lock_q;
  assign mult_o      = mult_q;
  assign div_o       = div_q;

endmodule
`default_nettype wire

// File: tb/tb_tb_fll_regbus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tb_fll_regbus
//  Brief    : Directed self-checking bench for the behavioural FLL model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tb_fll_regbus;

  logic        clk;
  logic        rst;
  logic        reg_valid;
  logic        reg_write;
  logic [47:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        reg_ready;
  logic        lock;
  logic [15:0] mult;
  logic [3:0]  div;

  int errs   = 0;
  int checks = 0;

  tb_fll_regbus #(
    .AddrWidth        (48),
    .DefaultMult      (16'd1),
    .DefaultLockCycles(16'd16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reg_valid_i(reg_valid),
    .reg_write_i(reg_write),
    .reg_addr_i (reg_addr),
    .reg_wdata_i(reg_wdata),
    .reg_wstrb_i(reg_wstrb),
    .reg_rdata_o(reg_rdata),
    .reg_error_o(reg_error),
    .reg_ready_o(reg_ready),
    .lock_o     (lock),
    .mult_o     (mult),
    .div_o      (div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access. Inputs change and outputs are sampled on the falling edge.
  // Returns on the falling edge of the ready cycle; lat counts cycles to ready.
  task automatic bus(input logic wr, input logic [47:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    reg_valid = 1'b1; reg_write = wr; reg_addr = addr; reg_wdata = wd; reg_wstrb = st;
    lat = -1; rd = 32'd0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (reg_ready) begin
        lat = i; rd = reg_rdata; er = reg_error;
        break;
      end
    end
    reg_valid = 1'b0;
    if (lat < 0) begin
      checks++; errs++;
      $display("FAIL bus_timeout addr=%h: no ready within 10 cycles", addr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    rst = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if ({reg_ready, reg_error, lock, mult, div, reg_rdata} !== 55'd0) begin errs++;
      $display("FAIL reset_outputs got rdy=%b err=%b lock=%b mult=%h div=%h rdata=%h expected all 0",
               reg_ready, reg_error, lock, mult, div, reg_rdata); end
    bus(1'b0, 48'h4, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0001 || er !== 1'b0) begin errs++;
      $display("FAIL reset_cfg1 got %h err=%b expected 00000001 err=0", rd, er); end
    checks++; if (lat !== 1) begin errs++;
      $display("FAIL ready_latency got %0d expected 1", lat); end
    @(negedge clk);
    checks++; if (reg_ready !== 1'b0) begin errs++;
      $display("FAIL ready_one_cycle got %b expected 0", reg_ready); end
    bus(1'b0, 48'h8, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0010) begin errs++;
      $display("FAIL reset_cfg2 got %h expected 00000010", rd); end
    bus(1'b0, 48'h0, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0000) begin errs++;
      $display("FAIL reset_status got %h expected 00000000", rd); end
  endtask

  task automatic test_back_to_back();
    logic r1, r2, r3; logic [31:0] d3;
    @(negedge clk);
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h4; reg_wstrb = 4'h0;
    @(negedge clk); r1 = reg_ready;
    reg_addr = 48'h8;
    @(negedge clk); r2 = reg_ready;
    @(negedge clk); r3 = reg_ready; d3 = reg_rdata;
    reg_valid = 1'b0;
    checks++; if ({r1, r2, r3} !== 3'b101) begin errs++;
      $display("FAIL b2b_ready_pattern got %b expected 101", {r1, r2, r3}); end
    checks++; if (d3 !== 32'h0000_0010) begin errs++;
      $display("FAIL b2b_second_rdata got %h expected 00000010", d3); end
  endtask

  task automatic test_lock();
    logic [31:0] rd; logic er; int lat; int rise;
    logic [15:0] mh [0:6]; logic [3:0] d16;
    d16 = 4'hF;
    for (int i = 0; i <= 6; i++) mh[i] = 16'hFFFF;
    bus(1'b1, 48'h4, 32'h8003_0005, 4'hF, rd, er, lat);
    mh[0] = mult;
    rise = -1;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      @(negedge clk);
      if (k <= 6) mh[k] = mult;
      if (k == 16) d16 = div;
      if (lock) rise = k;
    end
    checks++; if (rise !== 17) begin errs++;
      $display("FAIL lock_rise got cycle %0d expected 17", rise); end
    checks++; if (mh[0] !== 16'd0 || mh[1] !== 16'd1 || mh[3] !== 16'd3 || mh[5] !== 16'd5 || mh[6] !== 16'd5) begin errs++;
      $display("FAIL mult_ramp got %0d %0d %0d %0d %0d expected 0 1 3 5 5", mh[0], mh[1], mh[3], mh[5], mh[6]); end
    checks++; if (d16 !== 4'd0 || div !== 4'd3) begin errs++;
      $display("FAIL div_update got settle=%0d locked=%0d expected 0 and 3", d16, div); end
    bus(1'b0, 48'hC, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'd1) begin errs++;
      $display("FAIL relocks_1 got %h expected 00000001", rd); end
    bus(1'b0, 48'h0, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0005_0001) begin errs++;
      $display("FAIL status_locked got %h expected 00050001", rd); end
  endtask

  task automatic test_relock();
    logic [31:0] rd; logic er; int lat; int rise; logic l0; logic [15:0] m0, m1, m3;
    logic dropped;
    bus(1'b1, 48'h4, 32'h8003_0008, 4'hF, rd, er, lat);
    l0 = lock; m0 = mult; m1 = 16'hFFFF; m3 = 16'hFFFF;
    rise = -1;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      @(negedge clk);
      if (k == 1) m1 = mult;
      if (k == 3) m3 = mult;
      if (lock) rise = k;
    end
    checks++; if (l0 !== 1'b0) begin errs++;
      $display("FAIL relock_drop got lock=%b expected 0", l0); end
    checks++; if (m0 !== 16'd5 || m1 !== 16'd6 || m3 !== 16'd8) begin errs++;
      $display("FAIL relock_ramp got %0d %0d %0d expected 5 6 8", m0, m1, m3); end
    checks++; if (rise !== 17) begin errs++;
      $display("FAIL relock_rise got cycle %0d expected 17", rise); end
    bus(1'b1, 48'h4, 32'h8003_0008, 4'hF, rd, er, lat);
    dropped = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!lock) dropped = 1'b1;
      @(negedge clk);
    end
    checks++; if (dropped !== 1'b0) begin errs++;
      $display("FAIL identical_write_no_relock got a lock drop expected none"); end
    bus(1'b0, 48'hC, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'd2) begin errs++;
      $display("FAIL relocks_2 got %h expected 00000002", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic [47:0] ea [0:3]; logic ew [0:3];
    ea[0] = 48'h0;  ew[0] = 1'b1;
    ea[1] = 48'hC;  ew[1] = 1'b1;
    ea[2] = 48'h10; ew[2] = 1'b0;
    ea[3] = 48'h6;  ew[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(ew[i], ea[i], 32'hFFFF_FFFF, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'd0) begin errs++;
        $display("FAIL err_access_%0d addr=%h got err=%b rdata=%h expected err=1 rdata=0", i, ea[i], er, rd); end
    end
    bus(1'b0, 48'h4, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h8003_0008 || er !== 1'b0) begin errs++;
      $display("FAIL err_cfg1_unchanged got %h err=%b expected 80030008 err=0", rd, er); end
    bus(1'b0, 48'hC, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'd2 || lock !== 1'b1) begin errs++;
      $display("FAIL err_state_unchanged got relocks=%h lock=%b expected 2 and 1", rd, lock); end
    bus(1'b0, 48'h1234_5678_9008, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0010 || er !== 1'b0) begin errs++;
      $display("FAIL upper_addr_ignored got %h err=%b expected 00000010 err=0", rd, er); end
  endtask

  task automatic test_byte_strobes();
    logic [31:0] rd; logic er; int lat; logic any_lock;
    bus(1'b1, 48'h4, 32'h0000_0000, 4'hF, rd, er, lat);
    bus(1'b1, 48'h4, 32'hFFFF_FF07, 4'h1, rd, er, lat);
    bus(1'b1, 48'h4, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b0) begin errs++;
      $display("FAIL wstrb0_no_error got err=%b expected 0", er); end
    bus(1'b0, 48'h4, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0007) begin errs++;
      $display("FAIL byte_write_cfg1 got %h expected 00000007", rd); end
    any_lock = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (lock) any_lock = 1'b1;
      @(negedge clk);
    end
    checks++; if (any_lock !== 1'b0 || mult !== 16'd8) begin errs++;
      $display("FAIL idle_hold got lock_seen=%b mult=%0d expected 0 and 8", any_lock, mult); end
    bus(1'b1, 48'h8, 32'hABCD_0004, 4'h1, rd, er, lat);
    bus(1'b0, 48'h8, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0004) begin errs++;
      $display("FAIL byte_write_cfg2 got %h expected 00000004", rd); end
  endtask

  task automatic test_zero_lock_cycles();
    logic [31:0] rd; logic er; int lat; logic l0, l1; logic [3:0] d1;
    bus(1'b1, 48'h8, 32'h0000_0000, 4'hF, rd, er, lat);
    bus(1'b1, 48'h4, 32'h8000_0008, 4'hF, rd, er, lat);
    l0 = lock;
    @(negedge clk);
    l1 = lock; d1 = div;
    checks++; if ({l0, l1} !== 2'b01 || d1 !== 4'd0) begin errs++;
      $display("FAIL zero_lock_cycles got lock %b%b div=%0d expected 01 and 0", l0, l1, d1); end
    bus(1'b0, 48'hC, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'd3) begin errs++;
      $display("FAIL relocks_3 got %h expected 00000003", rd); end
  endtask

  task automatic test_reset_mid_settle();
    logic [31:0] rd; logic er; int lat; logic r0, r1, l_settle;
    bus(1'b1, 48'h8, 32'h0000_0010, 4'hF, rd, er, lat);
    bus(1'b1, 48'h4, 32'h8000_0002, 4'hF, rd, er, lat);
    repeat (2) @(negedge clk);
    l_settle = lock;
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h4; reg_wstrb = 4'h0;
    rst = 1'b1;
    @(negedge clk); r0 = reg_ready;
    reg_valid = 1'b0; rst = 1'b0;
    @(negedge clk); r1 = reg_ready;
    checks++; if (l_settle !== 1'b0) begin errs++;
      $display("FAIL settle_unlocked got lock=%b expected 0", l_settle); end
    checks++; if ({r0, r1} !== 2'b00) begin errs++;
      $display("FAIL reset_drops_response got ready %b%b expected 00", r0, r1); end
    checks++; if (lock !== 1'b0 || mult !== 16'd0 || div !== 4'd0) begin errs++;
      $display("FAIL reset_outputs_mid got lock=%b mult=%0d div=%0d expected 0 0 0", lock, mult, div); end
    bus(1'b0, 48'h4, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0001) begin errs++;
      $display("FAIL reset_cfg1_mid got %h expected 00000001", rd); end
    bus(1'b0, 48'hC, 32'd0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'd0) begin errs++;
      $display("FAIL reset_relocks_mid got %h expected 00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lock();
    test_relock();
    test_errors();
    test_byte_strobes();
    test_zero_lock_cycles();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
